// File: rtl/master_port.sv
// Serial master port: captures a request, waits for the slave, shifts out a 12-bit
// address (and 8-bit write data) LSB first, and for reads shifts in one byte.
module master_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mode,
    input  logic [11:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        slave_ready,
    input  logic        slave_valid,
    input  logic        rx_data,
    output logic        read_en,
    output logic        write_en,
    output logic        master_valid,
    output logic        master_ready,
    output logic        tx_address,
    output logic        tx_data,
    output logic [2:0]  dbg_state
);

    // Handshake: the slave is engaged only after slave_ready=1 is sampled in WAIT_SLAVE;
    // master_valid marks the 12 address/data bits; master_ready marks cycles where a
    // slave_valid=1 starts the 8-bit read burst, whose remaining 7 bits follow back to back.

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_SLAVE = 3'd1,
        ADDR_TX    = 3'd2,
        READ_WAIT  = 3'd3,
        READ_RX    = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_d;
    logic [3:0]  cnt;
    logic [7:0]  tcnt;
    logic [11:0] addr_q;
    logic [7:0]  wdata_q;
    logic        mode_q;
    logic [6:0]  rx_shift;
    logic [2:0]  rx_idx;
    logic        counting;

    assign rx_idx   = cnt[2:0] + 3'd1;
    assign counting = (state == ADDR_TX) || (state == READ_RX);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (req) state_d = WAIT_SLAVE;
            WAIT_SLAVE: if (slave_ready) state_d = ADDR_TX;
            ADDR_TX:    if (cnt == 4'd11) state_d = mode_q ? READ_WAIT : DONE;
            READ_WAIT: begin
                if (slave_valid) state_d = READ_RX;
                else if (tcnt == TIMEOUT_LAST) state_d = DONE;
            end
            READ_RX:    if (cnt == 4'd6) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mode_q   <= 1'b0;
            rx_shift <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_d;
            // Counters restart on every state change, so they never need to wrap.
            if (state_d != state) begin
                cnt  <= '0;
                tcnt <= '0;
            end else begin
                if (counting) cnt <= cnt + 4'd1;
                if (state == READ_WAIT) tcnt <= tcnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        mode_q  <= mode;
                    end
                end
                ADDR_TX: begin
                    if (cnt == 4'd11 && !mode_q) err <= 1'b0;
                end
                READ_WAIT: begin
                    if (slave_valid) rx_shift[0] <= rx_data;
                    else if (tcnt == TIMEOUT_LAST) err <= 1'b1;
                end
                READ_RX: begin
                    if (cnt == 4'd6) begin
                        rdata <= {rx_data, rx_shift};
                        err   <= 1'b0;
                    end else begin
                        rx_shift[rx_idx] <= rx_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign master_valid = (state == ADDR_TX);
    assign master_ready = (state == READ_WAIT) || (state == READ_RX);
    assign read_en      = master_valid && (cnt == 4'd0) && mode_q;
    assign write_en     = master_valid && (cnt == 4'd0) && !mode_q;
    assign tx_address   = master_valid && addr_q[cnt];
    assign tx_data      = master_valid && !mode_q && !cnt[3] && wdata_q[cnt[2:0]];
    assign dbg_state    = state;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: table of transactions, serial streams collected and
// compared, completion results checked through an expected-result queue.
module tb_master_port;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic        mode;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        slave_ready;
  logic        slave_valid;
  logic        rx_data;
  logic        read_en;
  logic        write_en;
  logic        master_valid;
  logic        master_ready;
  logic        tx_address;
  logic        tx_data;
  logic [2:0]  dbg_state;

  master_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .mode         (mode),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .rx_data      (rx_data),
    .read_en      (read_en),
    .write_en     (write_en),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .tx_address   (tx_address),
    .tx_data      (tx_data),
    .dbg_state    (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one record per transaction: stimulus, then expected results
  typedef struct {
    bit          mode;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          rdy_dly;
    int          sv_dly;
    logic [7:0]  rx;
    int          abort_at;
    bit          req_in_done;
    bit          exp_err;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t       vecs[13];
  logic [8:0] exp_q[$];
  int         tests;
  int         failed;
  int         done_seen;
  int         exp_done;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // driver: starts at a negedge in IDLE, ends at the negedge of the IDLE cycle after DONE
  task automatic run_txn(input vec_t v);
    logic [11:0] a_str;
    logic [11:0] d_str;
    logic [11:0] exp_d;
    logic [8:0]  expv;
    logic [2:0]  bidx;
    int          mv_n;
    int          re_n;
    int          we_n;
    bit          re0;
    bit          we0;
    bit          aborted;
    bit          seen;
    int          k;
    check("idle_before", busy, 0);
    req = 1'b1; mode = v.mode; addr = v.addr; wdata = v.wdata;
    slave_ready = 1'b0; slave_valid = 1'b0;
    if (v.abort_at < 0) begin
      exp_q.push_back({v.exp_err, v.exp_rdata});
      exp_done++;
    end

    mv_n = 0;
    for (int j = 0; j <= v.rdy_dly; j++) begin
      @(negedge clk);
      if (j == 0) check("busy_rise", busy, 1);
      if (master_valid || master_ready) mv_n++;
      req = 1'($urandom_range(0, 1));
      slave_ready = (j == v.rdy_dly);
    end
    check("wait_quiet", mv_n, 0);

    a_str = '0; d_str = '0; mv_n = 0; re_n = 0; we_n = 0; re0 = 0; we0 = 0; aborted = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_str[i] = tx_address;
      d_str[i] = tx_data;
      mv_n += int'(master_valid);
      re_n += int'(read_en);
      we_n += int'(write_en);
      if (i == 0) begin re0 = read_en; we0 = write_en; end
      req = 1'($urandom_range(0, 1));
      slave_ready = 1'($urandom_range(0, 1));
      if (i == v.abort_at) begin
        reset = 1'b0; req = 1'b0;
        @(negedge clk);
        check("abort_quiet", {busy, master_valid, done, err}, 0);
        check("abort_rdata", rdata, 0);
        reset = 1'b1; slave_ready = 1'b0;
        aborted = 1;
        break;
      end
    end

    if (!aborted) begin
      exp_d = v.mode ? 12'h000 : {4'h0, v.wdata};
      check("addr_stream", a_str, v.addr);
      check("data_stream", d_str, exp_d);
      check("valid_cycles", mv_n, 12);
      check("strobe_first", {re0, we0}, {v.mode, !v.mode});
      check("strobe_count", re_n + we_n, 1);

      k = 0; seen = 0;
      while (!seen && k < 40) begin
        @(negedge clk);
        if (done) seen = 1;
        else begin
          if (k == 0) check("ready_rise", master_ready, v.mode);
          if (v.mode && v.sv_dly >= 0 && k >= v.sv_dly && k < v.sv_dly + 8) begin
            bidx = 3'(k - v.sv_dly);
            slave_valid = (k == v.sv_dly);
            rx_data = v.rx[bidx];
          end else begin
            slave_valid = 1'b0;
            rx_data = 1'($urandom_range(0, 1));
          end
          req = 1'($urandom_range(0, 1));
          k++;
        end
      end
      slave_valid = 1'b0;
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h0;
      if (!seen) begin
        tests++; failed++;
        $display("FAIL done_wait: no done after 40 cycles, expected after %0d", v.exp_lat);
        req = 1'b0;
      end else begin
        check("latency", k, v.exp_lat);
        check("err", err, expv[8]);
        check("rdata", rdata, expv[7:0]);
        check("ready_in_done", master_ready, 0);
        req = v.req_in_done;
        @(negedge clk);
        check("idle_after", {busy, done}, 0);
        check("err_hold", err, expv[8]);
        if (!v.req_in_done) req = 1'b0;
      end
    end
  endtask

  initial begin
    tests = 0; failed = 0; done_seen = 0; exp_done = 0;
    //          mode  addr     wdata  rdy sv  rx     abort rid err rdata  lat
    vecs[0]  = '{1'b0, 12'hA5C, 8'h3B, 0, -1, 8'h00, -1, 1'b0, 1'b0, 8'h00, 0};
    vecs[1]  = '{1'b1, 12'h123, 8'h00, 5,  3, 8'hC6, -1, 1'b0, 1'b0, 8'hC6, 11};
    vecs[2]  = '{1'b1, 12'h7FF, 8'h00, 0, -1, 8'h00, -1, 1'b0, 1'b1, 8'hC6, 4};
    vecs[3]  = '{1'b0, 12'h000, 8'hFF, 2, -1, 8'h00, -1, 1'b0, 1'b0, 8'hC6, 0};
    vecs[4]  = '{1'b1, 12'hFFF, 8'h00, 0,  0, 8'h5A, -1, 1'b0, 1'b0, 8'h5A, 8};
    vecs[5]  = '{1'b0, 12'h801, 8'h80, 1, -1, 8'h00, -1, 1'b0, 1'b0, 8'h5A, 0};
    vecs[6]  = '{1'b1, 12'h456, 8'h00, 3,  2, 8'h81, -1, 1'b0, 1'b0, 8'h81, 10};
    vecs[7]  = '{1'b1, 12'h0AA, 8'h00, 0, -1, 8'h00, -1, 1'b0, 1'b1, 8'h81, 4};
    vecs[8]  = '{1'b0, 12'hFFF, 8'h01, 0, -1, 8'h00, -1, 1'b1, 1'b0, 8'h81, 0};
    vecs[9]  = '{1'b1, 12'h555, 8'h00, 0,  1, 8'h3E, -1, 1'b0, 1'b0, 8'h3E, 9};
    vecs[10] = '{1'b0, 12'h3C3, 8'hAA, 0, -1, 8'h00,  5, 1'b0, 1'b0, 8'h00, 0};
    vecs[11] = '{1'b0, 12'h0F0, 8'h55, 1, -1, 8'h00, -1, 1'b0, 1'b0, 8'h00, 0};
    vecs[12] = '{1'b1, 12'h321, 8'h00, 0, -1, 8'h00, -1, 1'b0, 1'b1, 8'h00, 4};

    reset = 1'b0; req = 1'b0; mode = 1'b0; addr = '0; wdata = '0;
    slave_ready = 1'b0; slave_valid = 1'b0; rx_data = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_status", {busy, done, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_serial", {master_valid, master_ready, read_en, write_en, tx_address, tx_data}, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    repeat (3) @(negedge clk);
    check("done_pulses", done_seen, exp_done);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for slave_valid on a read; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset: sampled on the clk rising edge, reset applied when reset=0.
REQ-004 req  in  1  transaction request from the master device; sampled only in IDLE.
REQ-005 mode  in  1  1=read, 0=write; captured with req.
REQ-006 addr  in  12  target address; captured with req.
REQ-007 wdata  in  8  write data; captured with req.
REQ-008 rdata  out  8  last successfully received read data.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  qualifies done; 1=read timeout.
REQ-012 slave_ready  in  1  slave able to accept a transaction.
REQ-013 slave_valid  in  1  slave is driving serial read data.
REQ-014 rx_data  in  1  serial read data from the slave, LSB first.
REQ-015 read_en, write_en  out  1 each  one-cycle transaction-type strobes to the slave.
REQ-016 master_valid  out  1  serial address/data stream valid.
REQ-017 master_ready  out  1  master ready to receive read data.
REQ-018 tx_address, tx_data  out  1 each  serial address and write data, LSB first.

Function
REQ-019 States: IDLE, WAIT_SLAVE, ADDR_TX, READ_WAIT, READ_RX, DONE; all outputs registered or decoded from registered state, with no combinational path from any input to any output.
REQ-020 IDLE: on req=1, capture addr/wdata/mode and go to WAIT_SLAVE; req is ignored in every other state.
REQ-021 WAIT_SLAVE: remain until slave_ready=1, then go to ADDR_TX with bit counter=0; there is no timeout in this state.
REQ-022 ADDR_TX: lasts exactly 12 cycles with master_valid=1.
  - tx_address = addr[cnt].
  - tx_data = wdata[cnt] when write and cnt<8, else 0.
REQ-023 read_en (read) or write_en (write) is 1 only in the first ADDR_TX cycle; the other strobe stays 0.
REQ-024 After the cnt=11 cycle: write goes to DONE; read goes to READ_WAIT with timeout counter=0.
REQ-025 READ_WAIT and READ_RX: master_ready=1; master_ready=0 in all other states.
REQ-026 READ_WAIT with slave_valid=1: sample rx_data as bit0, then go to READ_RX.
REQ-027 READ_WAIT with slave_valid=0: increment the timeout counter; on reaching TIMEOUT, go to DONE with err=1 and leave rdata unchanged.
REQ-028 READ_RX: sample rx_data into bits 1..7 on 7 consecutive cycles regardless of slave_valid, then load rdata and go to DONE with err=0.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; err holds its value until the next DONE.
REQ-030 A req held high during DONE is not accepted; it is accepted on the following IDLE cycle, so the minimum gap between done and busy re-asserting is 1 cycle.
REQ-031 tx_address and tx_data are 0 whenever master_valid=0.
REQ-032 Bit counter is 4 bits and timeout counter is 8 bits; neither wraps, since both are cleared on state entry.
REQ-033 Latency, measured from the req-sampling edge with slave_ready=1:
  - write: done high in cycle 14.
  - read: done high 8 cycles after slave_valid is first sampled high.

Reset
REQ-034 On reset=0, state←IDLE and all outputs←0, including rdata=0x00 and err=0; counters and captured registers are cleared.
REQ-035 Reset mid-transaction aborts immediately with no done pulse, and the block accepts req on the first cycle after reset returns to 1.

Verification
REQ-036 Write addr=0xA5C, wdata=0x3B, slave_ready=1 -> write_en pulse in cycle 2; tx_address serial stream equals 0xA5C LSB first over 12 cycles; tx_data stream is 1,1,0,1,1,1,0,0 then 0,0,0,0; done=1 with err=0 in cycle 14.
REQ-037 Read addr=0x123 while slave_ready is held 0 for 5 cycles -> no master_valid during those cycles; read_en pulses once after slave_ready rises; master_ready rises after the 12th address bit.
REQ-038 Read where the slave returns 0xC6 LSB first, starting 3 cycles after master_ready -> rdata=0xC6, done=1, err=0.
REQ-039 Read with TIMEOUT=4 and slave_valid never asserted -> done=1 with err=1 four cycles after READ_WAIT entry; rdata keeps its previous value.
REQ-040 reset=0 during the 6th ADDR_TX cycle -> next cycle busy=0, master_valid=0, no done pulse; a new write then completes normally.
REQ-041 req pulsed while busy=1 -> ignored, and exactly one transaction completes.
